// File: rtl/sdhci_dat_pkg.sv
// Shared types and constants for the SD DAT-line read path.
//   bus_width_e : DAT bus width selector (1, 4 or 8 active lanes)
//   dat_state_e : block reader FSM states
//   CRC16_POLY  : x^16 + x^12 + x^5 + 1, implicit x^16 term dropped
//   lane_mask   : active-lane mask for a bus width
//   lane_step   : bits of one byte delivered per lane cycle
package sdhci_dat_pkg;

  typedef enum logic [1:0] {
    BW1 = 2'd0,
    BW4 = 2'd1,
    BW8 = 2'd2
  } bus_width_e;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_START = 3'd1,
    ST_DAT        = 3'd2,
    ST_CRC        = 3'd3,
    ST_END_BIT    = 3'd4
  } dat_state_e;

  localparam logic [15:0] CRC16_POLY    = 16'h1021;
  localparam logic [3:0]  CRC_CYCLES_M1 = 4'd15;

  function automatic logic [7:0] lane_mask(input logic [1:0] bw);
    case (bw)
      BW4:     lane_mask = 8'h0F;
      BW8:     lane_mask = 8'hFF;
      default: lane_mask = 8'h01;
    endcase
  endfunction

  function automatic logic [3:0] lane_step(input logic [1:0] bw);
    case (bw)
      BW4:     lane_step = 4'd4;
      BW8:     lane_step = 4'd8;
      default: lane_step = 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/crc16_read.sv
// Serial CRC16 for one DAT lane, MSB-first. Shifting the payload followed by
// its transmitted CRC leaves a zero residue when the lane is error free.
//   clk_i, rst_i : system clock, synchronous active-high reset
//   clr_i        : synchronous clear at the start of each block
//   en_i         : shift one bit this cycle
//   din_i        : lane bit
//   crc_o        : current remainder
module crc16_read
  import sdhci_dat_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic        din_i,
  output logic [15:0] crc_o
);

  logic fb;

  assign fb = din_i ^ crc_o[15];

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      crc_o <= '0;
    end else if (en_i) begin
      crc_o <= {crc_o[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/dat_read_wide.sv
// SD DAT-line block reader: waits for the start bit, assembles received bytes
// into 32-bit words, checks per-lane CRC16 and the end bit, and sequences
// block_count blocks. Everything SD-side advances only on sd_clk_en_i.
//   clk_i, rst_i           : system clock, synchronous active-high reset
//   sd_clk_en_i            : SD bit-clock strobe
//   dat_i                  : DAT lanes
//   start_i, abort_i       : begin / cancel a transfer
//   block_size_i           : bytes per block
//   block_count_i          : blocks per transfer (0 reads one block)
//   bus_width_i            : bus_width_e
//   timeout_i              : enabled-cycle limit while waiting for a start bit
//   data_valid_o, data_o   : received word pulse (first byte in [7:0])
//   block_done_o, done_o   : end-of-block / end-of-transfer pulses
//   crc_err_o, end_bit_err_o, timeout_err_o : status, valid with the pulses
//
// state         | meaning
// --------------+-----------------------------------------------------
// ST_IDLE       | no transfer, waiting for start_i
// ST_WAIT_START | waiting for all active lanes low, timeout running
// ST_DAT        | receiving block payload
// ST_CRC        | receiving 16 CRC bits per lane, residual word flush
// ST_END_BIT    | checking end bit, next block or finish
module dat_read_wide
  import sdhci_dat_pkg::*;
#(
  parameter int MaxBlockBitSize = 12,
  parameter int BlockCountWidth = 16,
  parameter int DatWidth        = 8,
  parameter int TimeoutWidth    = 20
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       sd_clk_en_i,
  input  logic [DatWidth-1:0]        dat_i,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [MaxBlockBitSize-1:0] block_size_i,
  input  logic [BlockCountWidth-1:0] block_count_i,
  input  logic [1:0]                 bus_width_i,
  input  logic [TimeoutWidth-1:0]    timeout_i,
  output logic                       data_valid_o,
  output logic [31:0]                data_o,
  output logic                       block_done_o,
  output logic                       done_o,
  output logic                       crc_err_o,
  output logic                       end_bit_err_o,
  output logic                       timeout_err_o
);

  localparam int DatCntWidth = MaxBlockBitSize + 3;
  localparam logic [7:0] LaneExist = 8'((9'd1 << DatWidth) - 9'd1);

  dat_state_e state_q, state_d;

  logic                       adv;
  logic [7:0]                 dat_ext, mask, cur_byte, sh_q;
  logic [3:0]                 step;
  logic [2:0]                 bit_pos_q;
  logic                       byte_end;
  logic [1:0]                 byte_idx_q;
  logic [23:0]                wbuf_q;
  logic [BlockCountWidth-1:0] blk_cnt_q;
  logic [TimeoutWidth-1:0]    to_cnt_q;
  logic [TimeoutWidth:0]      to_next;
  logic [DatCntWidth-1:0]     dat_cnt_q, dat_len_m1;
  logic [3:0]                 crc_cnt_q;
  logic                       start_bit, to_hit, last_blk, crc_bad, end_bad, end_xfer;
  logic [DatWidth-1:0]        lane_crc_bad;
  logic [DatWidth-1:0][15:0]  crc_q;
  logic                       crc_clr, crc_en;

  // Reset and abort win over the strobe; gating here keeps every pulse quiet
  // in the cycle they are applied.
  assign adv      = sd_clk_en_i & ~abort_i & ~rst_i;
  assign dat_ext  = 8'(dat_i);
  assign mask     = lane_mask(bus_width_i) & LaneExist;
  assign step     = lane_step(bus_width_i);
  assign byte_end = ({1'b0, bit_pos_q} + step) == 4'd8;
  assign start_bit = (dat_ext & mask) == 8'h00;
  assign to_next  = {1'b0, to_cnt_q} + (TimeoutWidth + 1)'(1);
  assign to_hit   = to_next >= {1'b0, timeout_i};
  assign last_blk = blk_cnt_q == BlockCountWidth'(1);
  assign end_bad  = |(~dat_ext & mask);
  assign crc_bad  = |lane_crc_bad;
  assign end_xfer = last_blk | crc_bad | end_bad;

  always_comb begin
    case (bus_width_i)
      BW4:     dat_len_m1 = {2'b00, block_size_i, 1'b0} - DatCntWidth'(1);
      BW8:     dat_len_m1 = {3'b000, block_size_i} - DatCntWidth'(1);
      default: dat_len_m1 = {block_size_i, 3'b000} - DatCntWidth'(1);
    endcase
  end

  always_comb begin
    case (bus_width_i)
      BW4:     cur_byte = {sh_q[3:0], dat_ext[3:0]};
      BW8:     cur_byte = dat_ext;
      default: cur_byte = {sh_q[6:0], dat_ext[0]};
    endcase
  end

  assign crc_en  = adv & ((state_q == ST_DAT) | (state_q == ST_CRC));
  assign crc_clr = adv & (state_q != ST_WAIT_START) & (state_d == ST_WAIT_START);

  for (genvar g = 0; g < DatWidth; g++) begin : g_lane
    crc16_read u_crc (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (crc_clr),
      .en_i  (crc_en),
      .din_i (dat_i[g]),
      .crc_o (crc_q[g])
    );
    assign lane_crc_bad[g] = (|crc_q[g]) & mask[g];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else if (sd_clk_en_i) begin
      case (state_q)
        ST_IDLE:       if (start_i) state_d = ST_WAIT_START;
        ST_WAIT_START: begin
          if (start_bit)   state_d = ST_DAT;
          else if (to_hit) state_d = ST_IDLE;
        end
        ST_DAT:        if (dat_cnt_q == '0) state_d = ST_CRC;
        ST_CRC:        if (crc_cnt_q == '0) state_d = ST_END_BIT;
        ST_END_BIT:    state_d = end_xfer ? ST_IDLE : ST_WAIT_START;
        default:       state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    data_valid_o  = 1'b0;
    data_o        = 32'h0;
    block_done_o  = 1'b0;
    done_o        = 1'b0;
    crc_err_o     = 1'b0;
    end_bit_err_o = 1'b0;
    timeout_err_o = 1'b0;
    if (adv) begin
      case (state_q)
        ST_WAIT_START: begin
          if (!start_bit && to_hit) begin
            done_o        = 1'b1;
            timeout_err_o = 1'b1;
          end
        end
        ST_DAT: begin
          if (byte_end && byte_idx_q == 2'd3) begin
            data_valid_o = 1'b1;
            data_o       = {cur_byte, wbuf_q};
          end
        end
        ST_CRC: begin
          // Partial final word; unfilled bytes of wbuf_q are already zero.
          if (crc_cnt_q == CRC_CYCLES_M1 && byte_idx_q != 2'd0) begin
            data_valid_o = 1'b1;
            data_o       = {8'h00, wbuf_q};
          end
        end
        ST_END_BIT: begin
          block_done_o  = 1'b1;
          done_o        = end_xfer;
          crc_err_o     = crc_bad;
          end_bit_err_o = end_bad;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      blk_cnt_q  <= '0;
      to_cnt_q   <= '0;
      dat_cnt_q  <= '0;
      crc_cnt_q  <= '0;
      bit_pos_q  <= '0;
      sh_q       <= '0;
      byte_idx_q <= '0;
      wbuf_q     <= '0;
    end else if (adv) begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            blk_cnt_q  <= (block_count_i == '0) ? BlockCountWidth'(1) : block_count_i;
            to_cnt_q   <= '0;
            byte_idx_q <= '0;
            wbuf_q     <= '0;
          end
        end
        ST_WAIT_START: begin
          if (start_bit) begin
            dat_cnt_q <= dat_len_m1;
            bit_pos_q <= '0;
            sh_q      <= '0;
          end else begin
            to_cnt_q <= to_cnt_q + TimeoutWidth'(1);
          end
        end
        ST_DAT: begin
          sh_q      <= cur_byte;
          bit_pos_q <= bit_pos_q + step[2:0];
          if (byte_end) begin
            if (byte_idx_q == 2'd3) begin
              wbuf_q     <= '0;
              byte_idx_q <= '0;
            end else begin
              case (byte_idx_q)
                2'd0:    wbuf_q[7:0]   <= cur_byte;
                2'd1:    wbuf_q[15:8]  <= cur_byte;
                default: wbuf_q[23:16] <= cur_byte;
              endcase
              byte_idx_q <= byte_idx_q + 2'd1;
            end
          end
          if (dat_cnt_q == '0) crc_cnt_q <= CRC_CYCLES_M1;
          else                 dat_cnt_q <= dat_cnt_q - DatCntWidth'(1);
        end
        ST_CRC: begin
          if (crc_cnt_q == CRC_CYCLES_M1) begin
            wbuf_q     <= '0;
            byte_idx_q <= '0;
          end
          if (crc_cnt_q != '0) crc_cnt_q <= crc_cnt_q - 4'd1;
        end
        ST_END_BIT: begin
          if (!end_xfer) begin
            blk_cnt_q <= blk_cnt_q - BlockCountWidth'(1);
            to_cnt_q  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dat_read_wide.sv
// Scoreboard bench for dat_read_wide: each block's expected words and status
// events are queued as the block is generated and popped as the DUT emits them.
module tb_dat_read_wide;
  import sdhci_dat_pkg::*;

  localparam logic [3:0] K_DATA = 4'd1;
  localparam logic [3:0] K_BLK  = 4'd2;
  localparam logic [3:0] K_DONE = 4'd3;

  logic        clk = 1'b0;
  logic        rst, sd_clk_en, start, abort;
  logic [7:0]  dat;
  logic [11:0] block_size;
  logic [15:0] block_count;
  logic [1:0]  bus_width;
  logic [19:0] timeout;
  logic        data_valid, block_done, done, crc_err, end_bit_err, timeout_err;
  logic [31:0] data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int tick_cyc = 0;
  int last_valid_cyc = -1;
  int done_cyc = -1;
  int en_div   = 1;
  int n_valid  = 0;
  int n_blk    = 0;
  int n_done   = 0;
  bit mon_en   = 1'b0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dat_read_wide dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .sd_clk_en_i   (sd_clk_en),
    .dat_i         (dat),
    .start_i       (start),
    .abort_i       (abort),
    .block_size_i  (block_size),
    .block_count_i (block_count),
    .bus_width_i   (bus_width),
    .timeout_i     (timeout),
    .data_valid_o  (data_valid),
    .data_o        (data),
    .block_done_o  (block_done),
    .done_o        (done),
    .crc_err_o     (crc_err),
    .end_bit_err_o (end_bit_err),
    .timeout_err_o (timeout_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ev(input logic [3:0] k, input logic [2:0] e, input logic [31:0] d);
    return {25'b0, k, e, d};
  endfunction

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic bit_in);
    logic fb;
    fb = c[15] ^ bit_in;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  function automatic logic [7:0] act_mask(input logic [1:0] bw);
    if (bw == BW8) return 8'hFF;
    if (bw == BW4) return 8'h0F;
    return 8'h01;
  endfunction

  // Active lanes carry v, inactive lanes carry noise.
  function automatic logic [7:0] mix(input logic [7:0] m, input logic [7:0] v);
    return (v & m) | (8'($urandom) & ~m);
  endfunction

  task automatic sb_pop(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    if (sb.size() == 0) begin
      chk({tag, "_unexpected"}, obs, 64'h0);
    end else begin
      e = sb.pop_front();
      chk(tag, obs, e);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (data_valid) begin
        n_valid++;
        last_valid_cyc = cyc;
        sb_pop("data", ev(K_DATA, {crc_err, end_bit_err, timeout_err}, data));
      end
      if (block_done) begin
        n_blk++;
        sb_pop("blk", ev(K_BLK, {crc_err, end_bit_err, timeout_err}, data));
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
        sb_pop("done", ev(K_DONE, {crc_err, end_bit_err, timeout_err}, data));
      end
      if (!data_valid && !block_done && !done)
        chk("quiet", {29'b0, crc_err, end_bit_err, timeout_err, data}, 64'h0);
    end
  end

  task automatic sd_tick(input logic [7:0] d);
    dat = d;
    sd_clk_en = 1'b0;
    repeat (en_div - 1) begin
      @(posedge clk);
      #1;
    end
    sd_clk_en = 1'b1;
    tick_cyc = cyc;
    @(posedge clk);
    #1;
    sd_clk_en = 1'b0;
  endtask

  task automatic send_block(input logic [1:0] bw, input int size, input logic [7:0] base,
                            input bit crc_bad, input bit end_bad, input bit fin, input bit rst_mid);
    logic [7:0]  m, b, d;
    logic [7:0]  cq[$];
    logic [15:0] lcrc[8];
    logic [31:0] w;
    int nb, last_data_cyc;
    m  = act_mask(bw);
    w  = 32'h0;
    nb = 0;
    for (int l = 0; l < 8; l++) lcrc[l] = 16'h0;
    for (int k = 0; k < size; k++) begin
      b = base + 8'(k);
      w[nb*8 +: 8] = b;
      nb++;
      if (nb == 4) begin
        sb.push_back(ev(K_DATA, 3'b000, w));
        w  = 32'h0;
        nb = 0;
      end
      case (bw)
        BW8: cq.push_back(b);
        BW4: begin
          cq.push_back(mix(m, {4'h0, b[7:4]}));
          cq.push_back(mix(m, {4'h0, b[3:0]}));
        end
        default: for (int i = 7; i >= 0; i--) cq.push_back(mix(m, {7'h0, b[i]}));
      endcase
    end
    if (nb != 0) sb.push_back(ev(K_DATA, 3'b000, w));
    foreach (cq[c]) for (int l = 0; l < 8; l++) lcrc[l] = crc_upd(lcrc[l], cq[c][l]);

    sd_tick(mix(m, 8'hFF));
    sd_tick(mix(m, 8'hFF));
    sd_tick(mix(m, 8'h00));
    foreach (cq[c]) sd_tick(cq[c]);
    last_data_cyc = tick_cyc;
    if (size % 4 == 0) chk("word_cyc", 64'(last_valid_cyc), 64'(last_data_cyc));

    for (int j = 0; j < 16; j++) begin
      d = 8'h00;
      for (int l = 0; l < 8; l++) d[l] = lcrc[l][15-j];
      d = mix(m, d);
      if (crc_bad && j == 3) d[0] = ~d[0];
      sd_tick(d);
      if (j == 0 && size % 4 != 0) chk("resid_cyc", 64'(last_valid_cyc), 64'(tick_cyc));
      if (rst_mid && j == 5) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("post_rst", {26'b0, data_valid, block_done, done, crc_err, end_bit_err, timeout_err, data}, 64'h0);
        return;
      end
    end
    sb.push_back(ev(K_BLK, {crc_bad, end_bad, 1'b0}, 32'h0));
    if (fin) sb.push_back(ev(K_DONE, {crc_bad, end_bad, 1'b0}, 32'h0));
    d = mix(m, 8'hFF);
    if (end_bad) d[0] = 1'b0;
    sd_tick(d);
  endtask

  task automatic run_xfer(input logic [1:0] bw, input int size, input int count, input logic [7:0] base,
                          input int crc_blk, input int end_blk, input int rst_blk);
    int nblk;
    bit err;
    nblk        = (count == 0) ? 1 : count;
    bus_width   = bw;
    block_size  = 12'(size);
    block_count = 16'(count);
    start = 1'b1;
    sd_tick(8'hFF);
    start = 1'b0;
    for (int b = 0; b < nblk; b++) begin
      err = (b == crc_blk) || (b == end_blk);
      send_block(bw, size, base + 8'(b * 37), b == crc_blk, b == end_blk,
                 err || (b == nblk - 1), b == rst_blk);
      if (err || b == rst_blk) break;
    end
    repeat (3) sd_tick(8'hFF);
    chk("sb_drain", 64'(sb.size()), 64'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, b0, d0, s;
    rst = 1'b1; sd_clk_en = 1'b0; start = 1'b0; abort = 1'b0; dat = 8'hFF;
    block_size = '0; block_count = '0; bus_width = BW1; timeout = 20'd1000;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out", {26'b0, data_valid, block_done, done, crc_err, end_bit_err, timeout_err, data}, 64'h0);
    mon_en = 1'b1;

    v0 = n_valid; b0 = n_blk; d0 = n_done;
    run_xfer(BW8, 512, 2, 8'h00, -1, -1, -1);
    chk("bw8_valid", 64'(n_valid - v0), 64'd256);
    chk("bw8_blk", 64'(n_blk - b0), 64'd2);
    chk("bw8_done", 64'(n_done - d0), 64'd1);

    run_xfer(BW4, 6, 1, 8'h01, -1, -1, -1);

    b0 = n_blk;
    run_xfer(BW1, 5, 3, 8'h20, 1, -1, -1);
    chk("crc_blocks", 64'(n_blk - b0), 64'd2);
    repeat (2) sd_tick(8'hFF);
    sd_tick(8'h00);
    repeat (40) sd_tick(8'($urandom));

    run_xfer(BW1, 4, 2, 8'h55, -1, 0, -1);
    run_xfer(BW8, 3, 0, 8'hA0, -1, -1, -1);

    timeout = 20'd100;
    bus_width = BW1;
    sb.push_back(ev(K_DONE, 3'b001, 32'h0));
    start = 1'b1;
    sd_tick(8'hFF);
    start = 1'b0;
    s = tick_cyc;
    repeat (110) sd_tick(8'hFF);
    chk("to_cyc", 64'(done_cyc - s), 64'd100);
    chk("to_drain", 64'(sb.size()), 64'h0);
    timeout = 20'd1000;

    d0 = n_done;
    bus_width = BW8; block_size = 12'd16; block_count = 16'd1;
    start = 1'b1;
    sd_tick(8'hFF);
    start = 1'b0;
    sd_tick(8'hFF);
    sd_tick(8'h00);
    sb.push_back(ev(K_DATA, 3'b000, 32'h04030201));
    for (int k = 1; k <= 6; k++) sd_tick(8'(k));
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    repeat (3) sd_tick(8'hFF);
    chk("abort_done", 64'(n_done - d0), 64'd0);
    run_xfer(BW8, 16, 1, 8'h40, -1, -1, -1);

    en_div = 4;
    run_xfer(BW4, 7, 2, 8'h70, -1, -1, 0);
    d0 = n_done;
    run_xfer(BW4, 7, 2, 8'h90, -1, -1, -1);
    chk("div4_done", 64'(n_done - d0), 64'd1);
    en_div = 1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
